// File: rtl/regfile_seq_pkg.sv
// Shared types, default parameters and the index-valid helper for the sequentially cleared
// register file.
package regfile_seq_pkg;

  localparam int unsigned DefBits  = 8;
  localparam int unsigned DefRbits = 3;
  localparam int unsigned DefNreg  = 8;

  typedef enum logic {
    StClear,
    StReady
  } clr_state_e;

  // r0 and anything at or beyond nreg are hardwired to zero and never written.
  function automatic logic idx_valid(input int unsigned idx, input int unsigned nreg);
    return (idx != 0) && (idx < nreg);
  endfunction

endpackage

// File: rtl/regfile_seq_if.sv
// Write, read and debug signals of regfile_seq, grouped with master (core side) and slave
// (register file side) modports.
interface regfile_seq_if
  import regfile_seq_pkg::*;
#(
  parameter int unsigned BITS  = DefBits,
  parameter int unsigned RBITS = DefRbits
);

  logic             run;
  logic             we;
  logic [RBITS-1:0] rd;
  logic [BITS-1:0]  rd_din;
  logic [RBITS-1:0] rs1;
  logic [RBITS-1:0] rs2;
  logic [BITS-1:0]  rs1_dout;
  logic [BITS-1:0]  rs2_dout;
  logic             ready;
  logic [RBITS-1:0] dbg_sel;
  logic [BITS-1:0]  dbg_dout;

  modport master (
    output run, we, rd, rd_din, rs1, rs2, dbg_sel,
    input  rs1_dout, rs2_dout, ready, dbg_dout
  );

  modport slave (
    input  run, we, rd, rd_din, rs1, rs2, dbg_sel,
    output rs1_dout, rs2_dout, ready, dbg_dout
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Post-reset clear sequencer: walks r1..r[NREG-1] writing zero, then holds ready high until
// the next reset.
module regfile_clr_fsm
  import regfile_seq_pkg::*;
#(
  parameter int unsigned RBITS = DefRbits,
  parameter int unsigned NREG  = DefNreg
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             clr_we,
  output logic [RBITS-1:0] clr_idx,
  output logic             ready
);

  localparam logic [RBITS-1:0] LastIdx = RBITS'(NREG - 1);

  clr_state_e       state_q;
  logic [RBITS-1:0] cnt_q;
  logic             ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StClear;
      cnt_q   <= RBITS'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (cnt_q == LastIdx) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReady: ;
      endcase
    end
  end

  assign clr_we  = (state_q == StClear);
  assign clr_idx = cnt_q;
  assign ready   = ready_q;

endmodule

// File: rtl/regfile_seq.sv
// Register file with hardwired r0, a zeroing sequence after reset and a registered debug read.
// Define REGFILE_SEQ_BYPASS_EN to forward an accepted write to matching read ports.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int unsigned BITS  = DefBits,
  parameter int unsigned RBITS = DefRbits,
  parameter int unsigned NREG  = DefNreg
) (
  input logic         clk,
  input logic         rstn,
  regfile_seq_if.slave bus
);

  localparam int unsigned Depth = 1 << RBITS;

  // Entries 0 and >= NREG are never written and never read, so they fold away.
  logic [BITS-1:0]  mem [Depth];

  logic             clr_we;
  logic [RBITS-1:0] clr_idx;
  logic             ready;
  logic             wr_acc;
  logic [BITS-1:0]  rs1_rd;
  logic [BITS-1:0]  rs2_rd;
  logic [BITS-1:0]  dbg_rd;
  logic [BITS-1:0]  dbg_q;

  regfile_clr_fsm #(
    .RBITS(RBITS),
    .NREG (NREG)
  ) u_clr_fsm (
    .clk    (clk),
    .rstn   (rstn),
    .clr_we (clr_we),
    .clr_idx(clr_idx),
    .ready  (ready)
  );

  assign wr_acc = bus.run && bus.we && ready && idx_valid(32'(bus.rd), NREG);

  // Reset only steers the sequencer; storage is left untouched on a reset edge.
  always_ff @(posedge clk) begin
    if (rstn && clr_we) begin
      mem[clr_idx] <= '0;
    end else if (rstn && wr_acc) begin
      mem[bus.rd] <= bus.rd_din;
    end
  end

  always_comb begin
    rs1_rd = idx_valid(32'(bus.rs1), NREG) ? mem[bus.rs1] : '0;
    rs2_rd = idx_valid(32'(bus.rs2), NREG) ? mem[bus.rs2] : '0;
    dbg_rd = idx_valid(32'(bus.dbg_sel), NREG) ? mem[bus.dbg_sel] : '0;
  end

`ifdef REGFILE_SEQ_BYPASS_EN
  assign bus.rs1_dout = (wr_acc && (bus.rd == bus.rs1)) ? bus.rd_din : rs1_rd;
  assign bus.rs2_dout = (wr_acc && (bus.rd == bus.rs2)) ? bus.rd_din : rs2_rd;
`else
  assign bus.rs1_dout = rs1_rd;
  assign bus.rs2_dout = rs2_rd;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= dbg_rd;
    end
  end

  assign bus.dbg_dout = dbg_q;
  assign bus.ready    = ready;

endmodule
